// File: rtl/bp_be_lce_out_arb.sv
// Outbound LCE arbiter: per-channel skid FIFOs merged round-robin onto one port, plus an
// outstanding-message credit counter. Define BP_BE_LCE_ARB_FLUSH_EN to add the flush_i port.
module bp_be_lce_out_arb #(
  parameter int num_ch_p     = 3,
  parameter int data_width_p = 128,
  parameter int buf_els_p    = 2,
  parameter int credits_p    = 8,
  localparam int ch_id_width_lp  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1,
  localparam int credit_width_lp = $clog2(credits_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
`ifdef BP_BE_LCE_ARB_FLUSH_EN
  input  logic                               flush_i,
`endif
  input  logic [num_ch_p*data_width_p-1:0]   ch_data_i,
  input  logic [num_ch_p-1:0]                ch_v_i,
  output logic [num_ch_p-1:0]                ch_ready_o,
  output logic [data_width_p-1:0]            data_o,
  output logic [ch_id_width_lp-1:0]          ch_id_o,
  output logic                               v_o,
  input  logic                               ready_i,
  input  logic                               credit_return_i,
  output logic [credit_width_lp-1:0]         credit_count_o,
  output logic                               credits_full_o,
  output logic                               credits_empty_o
);

  localparam int ptr_width_lp = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
  localparam int cnt_width_lp = $clog2(buf_els_p + 1);

  logic [ch_id_width_lp-1:0]  r_rr_ptr;
  logic [ch_id_width_lp-1:0]  r_lock_id;
  logic                       r_lock;
  logic [credit_width_lp-1:0] r_credits;

  logic [num_ch_p-1:0]                    w_ne;
  logic [num_ch_p-1:0]                    w_enq;
  logic [num_ch_p-1:0]                    w_deq;
  logic [num_ch_p-1:0]                    w_keep;
  logic [num_ch_p-1:0][data_width_p-1:0]  w_head;
  logic [ch_id_width_lp-1:0]              w_gid;
  logic                                   w_any;
  logic                                   w_send;
  logic                                   w_flush;

`ifdef BP_BE_LCE_ARB_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  function automatic logic [ptr_width_lp-1:0] f_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(buf_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  for (genvar k = 0; k < num_ch_p; k++) begin : g_ch
    logic [data_width_p-1:0] r_mem [buf_els_p];
    logic [ptr_width_lp-1:0] r_rptr;
    logic [ptr_width_lp-1:0] r_wptr;
    logic [cnt_width_lp-1:0] r_cnt;

    assign w_ne[k]       = (r_cnt != '0);
    assign w_head[k]     = r_mem[r_rptr];
    assign w_deq[k]      = w_send & (w_gid == ch_id_width_lp'(k));
    // a full FIFO still accepts when its head leaves in the same cycle
    assign ch_ready_o[k] = (r_cnt != cnt_width_lp'(buf_els_p)) | w_deq[k];
    assign w_enq[k]      = ch_v_i[k] & ch_ready_o[k] & ~w_flush;
    assign w_keep[k]     = v_o & ~ready_i & (w_gid == ch_id_width_lp'(k));

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_rptr <= '0;
        r_wptr <= '0;
        r_cnt  <= '0;
      end else if (w_flush) begin
        // only the entry presented and stalled on the output survives a flush
        r_wptr <= w_keep[k] ? f_inc(r_rptr) : r_rptr;
        r_cnt  <= w_keep[k] ? cnt_width_lp'(1) : '0;
      end else begin
        if (w_enq[k]) begin
          r_mem[r_wptr] <= ch_data_i[k*data_width_p +: data_width_p];
          r_wptr        <= f_inc(r_wptr);
        end
        if (w_deq[k]) r_rptr <= f_inc(r_rptr);
        r_cnt <= r_cnt + cnt_width_lp'(w_enq[k]) - cnt_width_lp'(w_deq[k]);
      end
    end
  end

  always_comb begin
    w_gid = r_lock_id;
    if (!r_lock) begin
      w_gid = '0;
      // descending scan so the nearest non-empty channel after the pointer wins
      for (int i = num_ch_p - 1; i >= 0; i--) begin
        if (w_ne[ch_id_width_lp'((int'(r_rr_ptr) + i) % num_ch_p)])
          w_gid = ch_id_width_lp'((int'(r_rr_ptr) + i) % num_ch_p);
      end
    end
  end

  assign w_any           = |w_ne;
  assign credits_full_o  = (r_credits == credit_width_lp'(credits_p));
  assign credits_empty_o = (r_credits == '0);
  assign credit_count_o  = r_credits;
  assign v_o             = r_lock | (w_any & ~credits_full_o);
  assign w_send          = v_o & ready_i;
  assign data_o          = v_o ? w_head[w_gid] : '0;
  assign ch_id_o         = v_o ? w_gid : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_credits <= '0;
    end else begin
      r_lock    <= v_o & ~ready_i;
      r_lock_id <= w_gid;
      if (w_send)
        r_rr_ptr <= (w_gid == ch_id_width_lp'(num_ch_p - 1)) ? '0 : w_gid + ch_id_width_lp'(1);
      if (w_send && !credit_return_i)
        r_credits <= r_credits + credit_width_lp'(1);
      else if (!w_send && credit_return_i && !credits_empty_o)
        r_credits <= r_credits - credit_width_lp'(1);
    end
  end

`ifndef SYNTHESIS
  a_valid_needs_ready: assert property (@(posedge clk_i) disable iff (reset_i)
    (ch_v_i & ~ch_ready_o) == '0);
  a_no_return_at_zero: assert property (@(posedge clk_i) disable iff (reset_i)
    !(credit_return_i && credits_empty_o));
`endif

endmodule

// File: tb/tb_bp_be_lce_out_arb.sv
// Bench for bp_be_lce_out_arb: directed scenarios plus randomized traffic against a queue model.
module tb_bp_be_lce_out_arb;
  localparam int NCH = 3;
  localparam int DW  = 128;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             flush_i;
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]   ch_v_i;
  logic [NCH-1:0]   ch_ready_o;
  logic [DW-1:0]    data_o;
  logic [1:0]       ch_id_o;
  logic             v_o;
  logic             ready_i;
  logic             credit_return_i;
  logic [3:0]       credit_count_o;
  logic             credits_full_o;
  logic             credits_empty_o;

  int n_checks = 0;
  int n_errors = 0;

  bp_be_lce_out_arb #(.num_ch_p(NCH), .data_width_p(DW), .buf_els_p(2), .credits_p(8)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
`ifdef BP_BE_LCE_ARB_FLUSH_EN
    .flush_i(flush_i),
`endif
    .ch_data_i(ch_data_i),
    .ch_v_i(ch_v_i),
    .ch_ready_o(ch_ready_o),
    .data_o(data_o),
    .ch_id_o(ch_id_o),
    .v_o(v_o),
    .ready_i(ready_i),
    .credit_return_i(credit_return_i),
    .credit_count_o(credit_count_o),
    .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; ch_v_i = '0; ch_data_i = '0; ready_i = 1'b0;
    credit_return_i = 1'b0; flush_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) tick();
    n_checks++; if (v_o !== 1'b0) begin n_errors++; $display("FAIL reset_v got %b want 0", v_o); end
    n_checks++; if (ch_ready_o !== 3'b111) begin n_errors++; $display("FAIL reset_ready got %b want 111", ch_ready_o); end
    n_checks++; if (credits_empty_o !== 1'b1 || credits_full_o !== 1'b0) begin n_errors++; $display("FAIL reset_status got e=%b f=%b want e=1 f=0", credits_empty_o, credits_full_o); end
    n_checks++; if (credit_count_o !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", credit_count_o); end
    n_checks++; if (data_o !== '0 || ch_id_o !== 2'd0) begin n_errors++; $display("FAIL reset_data got %h/%0d want 0/0", data_o, ch_id_o); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_d [6];
    logic [1:0]    exp_id [6];
    int got;
    exp_d  = '{128'hA0, 128'hB0, 128'hC0, 128'hA1, 128'hB1, 128'hC1};
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    ch_v_i = 3'b111;
    ch_data_i = {128'hC0, 128'hB0, 128'hA0};
    tick();
    ch_data_i = {128'hC1, 128'hB1, 128'hA1};
    tick();
    ch_v_i = '0;
    ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      #1;
      if (v_o) begin
        n_checks++; if (data_o !== exp_d[got] || ch_id_o !== exp_id[got]) begin
          n_errors++; $display("FAIL rr_order[%0d] got %h/%0d want %h/%0d", got, data_o, ch_id_o, exp_d[got], exp_id[got]);
        end
        got++;
      end
      tick();
    end
    n_checks++; if (got !== 6) begin n_errors++; $display("FAIL rr_sends got %0d want 6", got); end
    n_checks++; if (credit_count_o !== 4'd6) begin n_errors++; $display("FAIL rr_count got %0d want 6", credit_count_o); end
    // reset mid-operation drops outstanding credits
    ch_v_i = 3'b001; ch_data_i = {128'h0, 128'h0, 128'h77};
    tick();
    do_reset();
    #1;
    n_checks++; if (credit_count_o !== 4'd0 || v_o !== 1'b0 || ch_ready_o !== 3'b111) begin
      n_errors++; $display("FAIL midreset got cnt=%0d v=%b rdy=%b want 0 0 111", credit_count_o, v_o, ch_ready_o);
    end
  endtask

  task automatic test_lock();
    do_reset();
    ch_v_i = 3'b010; ch_data_i = {128'h0, 128'hB0, 128'h0};
    tick();
    ch_v_i = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin ch_v_i = 3'b001; ch_data_i = {128'h0, 128'h0, 128'hA0}; end
      #1;
      n_checks++; if (v_o !== 1'b1 || data_o !== 128'hB0 || ch_id_o !== 2'd1) begin
        n_errors++; $display("FAIL lock_hold[%0d] got v=%b %h/%0d want 1 b0/1", i, v_o, data_o, ch_id_o);
      end
      tick();
      ch_v_i = '0;
    end
    ready_i = 1'b1;
    #1;
    n_checks++; if (v_o !== 1'b1 || data_o !== 128'hB0 || ch_id_o !== 2'd1) begin
      n_errors++; $display("FAIL lock_first got v=%b %h/%0d want 1 b0/1", v_o, data_o, ch_id_o);
    end
    tick();
    n_checks++; if (v_o !== 1'b1 || data_o !== 128'hA0 || ch_id_o !== 2'd0) begin
      n_errors++; $display("FAIL lock_second got v=%b %h/%0d want 1 a0/0", v_o, data_o, ch_id_o);
    end
    tick();
    n_checks++; if (v_o !== 1'b0 || credit_count_o !== 4'd2) begin
      n_errors++; $display("FAIL lock_after got v=%b cnt=%0d want 0 2", v_o, credit_count_o);
    end
  endtask

  task automatic test_credit_limit();
    int pushed, sends;
    do_reset();
    ready_i = 1'b1;
    pushed = 0; sends = 0;
    for (int c = 0; c < 40; c++) begin
      ch_v_i = '0;
      #1;
      if (pushed < 10 && ch_ready_o[0]) begin
        ch_v_i[0] = 1'b1; ch_data_i[DW-1:0] = DW'(256 + pushed); pushed++;
      end
      #1;
      if (v_o) begin
        n_checks++; if (data_o !== DW'(256 + sends)) begin
          n_errors++; $display("FAIL credit_data[%0d] got %h want %h", sends, data_o, DW'(256 + sends));
        end
        sends++;
      end
      tick();
    end
    ch_v_i = '0;
    #1;
    n_checks++; if (sends !== 8 || credits_full_o !== 1'b1 || v_o !== 1'b0 || credit_count_o !== 4'd8) begin
      n_errors++; $display("FAIL credit_full got sends=%0d full=%b v=%b cnt=%0d want 8 1 0 8", sends, credits_full_o, v_o, credit_count_o);
    end
    credit_return_i = 1'b1;
    tick();
    credit_return_i = 1'b0;
    #1;
    n_checks++; if (v_o !== 1'b1 || data_o !== DW'(264)) begin
      n_errors++; $display("FAIL credit_resend got v=%b %h want 1 108", v_o, data_o);
    end
    tick();
    n_checks++; if (credit_count_o !== 4'd8 || credits_full_o !== 1'b1) begin
      n_errors++; $display("FAIL credit_refull got cnt=%0d full=%b want 8 1", credit_count_o, credits_full_o);
    end
    credit_return_i = 1'b1;
    tick();
    #1;
    n_checks++; if (v_o !== 1'b1 || data_o !== DW'(265) || credit_count_o !== 4'd7) begin
      n_errors++; $display("FAIL credit_pre_same got v=%b %h cnt=%0d want 1 109 7", v_o, data_o, credit_count_o);
    end
    tick();
    credit_return_i = 1'b0;
    n_checks++; if (credit_count_o !== 4'd7) begin
      n_errors++; $display("FAIL credit_same got cnt=%0d want 7", credit_count_o);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    ch_v_i = 3'b100; ch_data_i = {128'hC0, 128'h0, 128'h0};
    tick();
    #1;
    n_checks++; if (ch_ready_o[2] !== 1'b1) begin n_errors++; $display("FAIL full_one got rdy=%b want 1", ch_ready_o[2]); end
    ch_data_i = {128'hC1, 128'h0, 128'h0};
    tick();
    ch_v_i = '0;
    #1;
    n_checks++; if (ch_ready_o[2] !== 1'b0) begin n_errors++; $display("FAIL full_two got rdy=%b want 0", ch_ready_o[2]); end
    ready_i = 1'b1;
    #1;
    n_checks++; if (ch_ready_o[2] !== 1'b1 || v_o !== 1'b1 || data_o !== 128'hC0) begin
      n_errors++; $display("FAIL full_deq got rdy=%b v=%b %h want 1 1 c0", ch_ready_o[2], v_o, data_o);
    end
    ch_v_i = 3'b100; ch_data_i = {128'hC2, 128'h0, 128'h0};
    tick();
    ch_v_i = '0;
    n_checks++; if (data_o !== 128'hC1) begin n_errors++; $display("FAIL full_next got %h want c1", data_o); end
    tick();
    n_checks++; if (v_o !== 1'b1 || data_o !== 128'hC2) begin n_errors++; $display("FAIL full_third got v=%b %h want 1 c2", v_o, data_o); end
    tick();
    n_checks++; if (v_o !== 1'b0) begin n_errors++; $display("FAIL full_drain got v=%b want 0", v_o); end
  endtask

`ifdef BP_BE_LCE_ARB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    ch_v_i = 3'b011; ch_data_i = {128'h0, 128'hB0, 128'hA0};
    tick();
    ch_v_i = 3'b001; ch_data_i = {128'h0, 128'h0, 128'hA1};
    tick();
    ch_v_i = '0;
    flush_i = 1'b1;
    #1;
    n_checks++; if (data_o !== 128'hA0) begin n_errors++; $display("FAIL flush_pre got %h want a0", data_o); end
    tick();
    flush_i = 1'b0;
    ready_i = 1'b1;
    #1;
    n_checks++; if (v_o !== 1'b1 || data_o !== 128'hA0 || ch_id_o !== 2'd0) begin
      n_errors++; $display("FAIL flush_keep got v=%b %h/%0d want 1 a0/0", v_o, data_o, ch_id_o);
    end
    tick();
    repeat (3) tick();
    n_checks++; if (v_o !== 1'b0 || credit_count_o !== 4'd1) begin
      n_errors++; $display("FAIL flush_after got v=%b cnt=%0d want 0 1", v_o, credit_count_o);
    end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] mq [NCH][$];
    int  mptr, mlock_id, mcred, mid;
    bit  mlock, mv, msend, mret;
    logic [NCH-1:0] mrdy;
    logic [DW-1:0]  d;
    do_reset();
    mptr = 0; mlock = 0; mlock_id = 0; mcred = 0;
    for (int c = 0; c < 400; c++) begin
      ready_i = ($urandom_range(3) != 0);
      mret = (mcred > 0) && ($urandom_range(3) == 0);
      credit_return_i = mret;
      mv = 0; mid = 0;
      if (mlock) begin
        mv = 1; mid = mlock_id;
      end else if (mcred < 8) begin
        for (int i = 0; i < NCH; i++) begin
          if (mq[(mptr + i) % NCH].size() > 0) begin mv = 1; mid = (mptr + i) % NCH; break; end
        end
      end
      msend = mv && ready_i;
      for (int k = 0; k < NCH; k++) mrdy[k] = (mq[k].size() < 2) || (msend && mid == k);
      ch_v_i = '0;
      for (int k = 0; k < NCH; k++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        ch_data_i[k*DW +: DW] = d;
        if (mrdy[k] && $urandom_range(1) == 1) ch_v_i[k] = 1'b1;
      end
      #1;
      n_checks++; if (v_o !== mv) begin n_errors++; $display("FAIL rand_v cyc %0d got %b want %b", c, v_o, mv); end
      if (mv) begin
        n_checks++; if (data_o !== mq[mid][0] || ch_id_o !== 2'(mid)) begin
          n_errors++; $display("FAIL rand_data cyc %0d got %h/%0d want %h/%0d", c, data_o, ch_id_o, mq[mid][0], mid);
        end
      end
      n_checks++; if (ch_ready_o !== mrdy) begin n_errors++; $display("FAIL rand_ready cyc %0d got %b want %b", c, ch_ready_o, mrdy); end
      n_checks++; if (credit_count_o !== 4'(mcred) || credits_full_o !== (mcred == 8) || credits_empty_o !== (mcred == 0)) begin
        n_errors++; $display("FAIL rand_credit cyc %0d got %0d f=%b e=%b want %0d", c, credit_count_o, credits_full_o, credits_empty_o, mcred);
      end
      if (msend) begin
        void'(mq[mid].pop_front());
        mptr = (mid + 1) % NCH;
      end
      mlock = mv && !ready_i;
      mlock_id = mid;
      mcred = mcred + (msend ? 1 : 0) - (mret ? 1 : 0);
      for (int k = 0; k < NCH; k++) if (ch_v_i[k]) mq[k].push_back(ch_data_i[k*DW +: DW]);
      tick();
    end
    ch_v_i = '0; credit_return_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_credit_limit();
    test_fifo_full();
`ifdef BP_BE_LCE_ARB_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
